// File: rtl/fpu_pipe_fwd_sb_if.sv
// Signal bundle between float issue/FRF/long-latency unit and the forwarding controller.
// slave = controller side, master = issue/FRF/long-unit side.
interface fpu_pipe_fwd_sb_if #(
   parameter int data_width_p = 32,
   parameter int addr_w_p     = 5
);
   logic                    stall_i;
   logic                    flush_i;
   logic                    id_v_i;
   logic [addr_w_p-1:0]     id_rs1_i;
   logic [addr_w_p-1:0]     id_rs2_i;
   logic                    id_reads1_i;
   logic                    id_reads2_i;
   logic [addr_w_p-1:0]     id_rd_i;
   logic                    id_writes_i;
   logic                    id_is_load_i;
   logic                    id_is_long_i;
   logic                    long_ready_i;
   logic [data_width_p-1:0] rf_rs1_i;
   logic [data_width_p-1:0] rf_rs2_i;
   logic [data_width_p-1:0] exe_result_i;
   logic [data_width_p-1:0] load_data_i;
   logic                    long_v_i;
   logic [addr_w_p-1:0]     long_rd_i;
   logic [data_width_p-1:0] long_data_i;
   logic                    long_yumi_o;
   logic                    long_issue_o;
   logic                    issue_o;
   logic                    dep_stall_o;
   logic [data_width_p-1:0] rs1_val_o;
   logic [data_width_p-1:0] rs2_val_o;
   logic                    rf_w_v_o;
   logic [addr_w_p-1:0]     rf_w_addr_o;
   logic [data_width_p-1:0] rf_w_data_o;

   modport slave (
      input  stall_i, flush_i, id_v_i, id_rs1_i, id_rs2_i, id_reads1_i, id_reads2_i,
             id_rd_i, id_writes_i, id_is_load_i, id_is_long_i, long_ready_i,
             rf_rs1_i, rf_rs2_i, exe_result_i, load_data_i,
             long_v_i, long_rd_i, long_data_i,
      output long_yumi_o, long_issue_o, issue_o, dep_stall_o, rs1_val_o, rs2_val_o,
             rf_w_v_o, rf_w_addr_o, rf_w_data_o
   );

   modport master (
      output stall_i, flush_i, id_v_i, id_rs1_i, id_rs2_i, id_reads1_i, id_reads2_i,
             id_rd_i, id_writes_i, id_is_load_i, id_is_long_i, long_ready_i,
             rf_rs1_i, rf_rs2_i, exe_result_i, load_data_i,
             long_v_i, long_rd_i, long_data_i,
      input  long_yumi_o, long_issue_o, issue_o, dep_stall_o, rs1_val_o, rs2_val_o,
             rf_w_v_o, rf_w_addr_o, rf_w_data_o
   );
endinterface

// File: rtl/fpu_pipe_fwd_sb.sv
// Float operand bypass, hazard detection and FRF write arbitration for a depth_p-stage pipe
// plus a long-latency scoreboard. Define FPU_FWD_EXE_BYPASS_EN to forward exe_result_i from stage 0.
module fpu_pipe_fwd_sb #(
   parameter int data_width_p = 32,
   parameter int reg_els_p    = 32,
   parameter int depth_p      = 4,
   parameter int load_stage_p = 1
) (
   input logic              clk,
   input logic              reset,
   fpu_pipe_fwd_sb_if.slave io
);
   localparam int addr_w_lp = $clog2(reg_els_p);
   localparam int tail_lp   = depth_p - 1;

`ifdef FPU_FWD_EXE_BYPASS_EN
   localparam logic exe_bypass_lp = 1'b1;
`else
   localparam logic exe_bypass_lp = 1'b0;
`endif

   logic [depth_p-1:0]      wr_q, wr_d;
   logic [depth_p-1:0]      ld_q, ld_d;
   logic [depth_p-1:0]      dv_q, dv_d;
   logic [addr_w_lp-1:0]    rd_q   [depth_p];
   logic [addr_w_lp-1:0]    rd_d   [depth_p];
   logic [data_width_p-1:0] data_q [depth_p];
   logic [data_width_p-1:0] data_d [depth_p];
   logic [reg_els_p-1:0]    sb_q, sb_d;

   logic                    issue, long_issue, dep_stall, waw;
   logic                    tail_w, long_w, rf_w_v;
   logic [addr_w_lp-1:0]    rf_w_addr;
   logic [data_width_p-1:0] rf_w_data;

   logic [1:0][addr_w_lp-1:0]    rs;
   logic [1:0]                   rs_reads, rs_haz, hit, hit_dv;
   logic [1:0][data_width_p-1:0] rf_val, rs_val;

   assign rs       = {io.id_rs2_i, io.id_rs1_i};
   assign rs_reads = {io.id_reads2_i, io.id_reads1_i};
   assign rf_val   = {io.rf_rs2_i, io.rf_rs1_i};

   // Tail owns the write port; a long result only slips into cycles the tail leaves empty.
   always_comb begin
      tail_w    = wr_q[tail_lp] & ~io.stall_i;
      long_w    = io.long_v_i & ~io.stall_i & ~tail_w;
      rf_w_v    = tail_w | long_w;
      rf_w_addr = '0;
      rf_w_data = '0;
      if (tail_w) begin
         rf_w_addr = rd_q[tail_lp];
         rf_w_data = data_q[tail_lp];
      end else if (long_w) begin
         rf_w_addr = io.long_rd_i;
         rf_w_data = io.long_data_i;
      end
   end

   // Priority builds up from lowest: FRF, write-through, oldest stage ... stage 0.
   always_comb begin
      rs_val = rf_val;
      hit    = '0;
      hit_dv = '0;
      rs_haz = '0;
      for (int p = 0; p < 2; p++) begin
         if (rf_w_v && (rf_w_addr == rs[p])) begin
            rs_val[p] = rf_w_data;
         end
         for (int s = tail_lp; s >= 1; s--) begin
            if (wr_q[s] && (rd_q[s] == rs[p])) begin
               hit[p]    = 1'b1;
               hit_dv[p] = dv_q[s];
               rs_val[p] = data_q[s];
            end
         end
         if (wr_q[0] && (rd_q[0] == rs[p])) begin
            hit[p]    = 1'b1;
            hit_dv[p] = exe_bypass_lp & ~ld_q[0];
            rs_val[p] = io.exe_result_i;
         end
         rs_haz[p] = rs_reads[p] & (sb_q[rs[p]] | (hit[p] & ~hit_dv[p]));
      end
   end

   always_comb begin
      waw = io.id_writes_i & sb_q[io.id_rd_i];
      for (int s = 0; s < depth_p; s++) begin
         if (io.id_is_long_i && wr_q[s] && (rd_q[s] == io.id_rd_i)) begin
            waw = 1'b1;
         end
      end
   end

   assign dep_stall  = io.id_v_i & ((|rs_haz) | waw);
   assign issue      = io.id_v_i & ~dep_stall & ~io.stall_i & ~io.flush_i
                     & ~(io.id_is_long_i & ~io.long_ready_i);
   assign long_issue = issue & io.id_is_long_i;

   always_comb begin
      wr_d   = wr_q;
      ld_d   = ld_q;
      dv_d   = dv_q;
      rd_d   = rd_q;
      data_d = data_q;
      sb_d   = sb_q;
      if (!io.stall_i) begin
         for (int s = tail_lp; s >= 1; s--) begin
            wr_d[s]   = wr_q[s-1];
            ld_d[s]   = ld_q[s-1];
            dv_d[s]   = dv_q[s-1];
            rd_d[s]   = rd_q[s-1];
            data_d[s] = data_q[s-1];
         end
         wr_d[1] = wr_q[0] & ~io.flush_i;
         if (!ld_q[0]) begin
            data_d[1] = io.exe_result_i;
            dv_d[1]   = 1'b1;
         end
         if (ld_q[load_stage_p]) begin
            data_d[load_stage_p+1] = io.load_data_i;
            dv_d[load_stage_p+1]   = 1'b1;
         end
         wr_d[0]   = issue & ~io.id_is_long_i & io.id_writes_i;
         ld_d[0]   = issue & ~io.id_is_long_i & io.id_is_load_i;
         dv_d[0]   = 1'b0;
         rd_d[0]   = io.id_rd_i;
         data_d[0] = '0;
      end
      // Set after clear so a same-cycle re-issue to the returning register stays pending.
      if (long_w) begin
         sb_d[io.long_rd_i] = 1'b0;
      end
      if (long_issue && io.id_writes_i) begin
         sb_d[io.id_rd_i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         ld_q <= '0;
         dv_q <= '0;
         sb_q <= '0;
         for (int s = 0; s < depth_p; s++) begin
            rd_q[s]   <= '0;
            data_q[s] <= '0;
         end
      end else begin
         wr_q   <= wr_d;
         ld_q   <= ld_d;
         dv_q   <= dv_d;
         sb_q   <= sb_d;
         rd_q   <= rd_d;
         data_q <= data_d;
      end
   end

   assign io.issue_o      = issue;
   assign io.long_issue_o = long_issue;
   assign io.dep_stall_o  = dep_stall;
   assign io.long_yumi_o  = long_w;
   assign io.rs1_val_o    = rs_val[0];
   assign io.rs2_val_o    = rs_val[1];
   assign io.rf_w_v_o     = rf_w_v;
   assign io.rf_w_addr_o  = rf_w_addr;
   assign io.rf_w_data_o  = rf_w_data;
endmodule
